cache_arbiter: RTL

- Shares the single physical-memory line port between the I-cache (instruction fetch misses) and the D-cache (load/store misses and writebacks).
- Serves one line transaction at a time. Breaks ties round-robin so neither requester starves.
- Keeps saturating per-requester grant counters for performance analysis.
- Sits between the two caches and the memory model; the pipeline's IF/MA stall signals follow from the cache responses it returns.

---
 rtl/cache_arbiter_pkg.sv | 12 +
 rtl/sat_counter.sv | 20 ++
 rtl/cache_arbiter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/cache_arbiter_pkg.sv
// arbiter_types: shared FSM/grant enums and default widths for cache_arbiter
// Contents:
//   arb_state_t  - arbiter FSM states
//   grant_t      - identity of the most recently granted requester
//   DEF_*        - default parameter values
package arbiter_types;
    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} arb_state_t;
    typedef enum logic {GRANT_I, GRANT_D} grant_t;
    localparam int DEF_LINE_WIDTH = 256;
    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_CNT_WIDTH  = 32;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping
// Ports:
//   clk, rst - clock, synchronous active-high reset (clears count)
//   inc      - advance by one when not already saturated
//   count    - current value
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);
    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (inc && count != '1)
            count <= count + 1'b1;
    end
endmodule

// File: rtl/cache_arbiter.sv
// cache_arbiter: round-robin sharing of one memory line port between I-cache and D-cache
// Ports:
//   clk, rst                         - clock, synchronous active-high reset
//   i_read/i_address                 - I-cache line read request (held until i_resp)
//   i_rdata/i_resp                   - I-cache returned line and completion
//   d_read/d_write/d_address/d_wdata - D-cache line read or writeback request
//   d_rdata/d_resp                   - D-cache returned line and completion
//   mem_*                            - registered strobes/address/data to memory, rdata/resp back
//   i_grant_count/d_grant_count      - saturating per-requester grant counters
module cache_arbiter
    import arbiter_types::*;
#(
    parameter int LINE_WIDTH = DEF_LINE_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp,
    output logic [CNT_WIDTH-1:0]  i_grant_count,
    output logic [CNT_WIDTH-1:0]  d_grant_count
);
    arb_state_t            r_state;
    grant_t                r_last_grant;
    logic                  r_mem_read;
    logic                  r_mem_write;
    logic [ADDR_WIDTH-1:0] r_mem_address;
    logic [LINE_WIDTH-1:0] r_mem_wdata;
    logic                  w_i_req;
    logic                  w_d_req;
    logic                  w_grant_i;
    logic                  w_grant_d;

    assign w_i_req = i_read;
    assign w_d_req = d_read | d_write;
    // On a tie the requester that was not served last wins
    assign w_grant_d = (r_state == IDLE) && w_d_req && (!w_i_req || r_last_grant == GRANT_I);
    assign w_grant_i = (r_state == IDLE) && w_i_req && !w_grant_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_last_grant  <= GRANT_I;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_address <= '0;
            r_mem_wdata   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_i) begin
                        r_state       <= SERVE_I;
                        r_last_grant  <= GRANT_I;
                        r_mem_read    <= 1'b1;
                        r_mem_write   <= 1'b0;
                        r_mem_address <= i_address;
                    end else if (w_grant_d) begin
                        // read+write together is illegal; resolved as a write
                        r_state       <= SERVE_D;
                        r_last_grant  <= GRANT_D;
                        r_mem_read    <= ~d_write;
                        r_mem_write   <= d_write;
                        r_mem_address <= d_address;
                        r_mem_wdata   <= d_wdata;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (mem_resp) begin
                        r_state     <= IDLE;
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_mem_read  <= 1'b0;
                    r_mem_write <= 1'b0;
                end
            endcase
        end
    end

    assign mem_read    = r_mem_read;
    assign mem_write   = r_mem_write;
    assign mem_address = r_mem_address;
    assign mem_wdata   = r_mem_wdata;
    assign i_resp      = (r_state == SERVE_I) && mem_resp;
    assign d_resp      = (r_state == SERVE_D) && mem_resp;
    assign i_rdata     = mem_rdata;
    assign d_rdata     = mem_rdata;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_i_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_grant_i),
        .count (i_grant_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_d_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_grant_d),
        .count (d_grant_count)
    );

    a_no_rw_conflict: assert property (@(posedge clk) disable iff (rst) !(d_read && d_write));
endmodule
